demux4_stream: RTL and testbench

- 1-to-4 stream demultiplexer: the inverse of the 4->1 select path.
- Accepts one DATA_W word per handshake, tagged with a 2-bit select, and delivers it to one of four output channels.
- Each output channel has its own one-entry registered slot with a valid/ready handshake, so each channel applies backpressure independently.
- Sits between a single producer and four consumers.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_slot.sv | 31 +++
 rtl/demux4_stream.sv | 39 +++
 tb/tb_demux4_stream.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, select type and one-hot decode for the 1-to-4 stream demux.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [NUM_CH-1:0] onehot(input sel_t s);
        return NUM_CH'(1) << s;
    endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry registered output slot with valid/ready handshake.
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              can_fill
);
    assign can_fill = !valid || ready;

    // fill beats drain so a simultaneous fill/drain keeps valid high at full rate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            data  <= fill_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: routes each accepted word to one of four independently backpressured slots.
module demux4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          flush,
    output logic [NUM_CH-1:0]             out_valid,
    input  logic [NUM_CH-1:0]             out_ready,
    output logic [NUM_CH-1:0][DATA_W-1:0] out_data,
    output logic                          busy
);
    logic [NUM_CH-1:0] hot;
    logic [NUM_CH-1:0] can_fill;

    assign hot      = onehot(sel_t'(in_sel));
    assign in_ready = !flush && can_fill[in_sel];
    assign busy     = |out_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .fill     (in_valid && in_ready && hot[g]),
            .fill_data(in_data),
            .ready    (out_ready[g]),
            .valid    (out_valid[g]),
            .data     (out_data[g]),
            .can_fill (can_fill[g])
        );
    end
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: table vectors, directed corner sequences and random traffic against a slot model.
module tb_demux4_stream;
    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic [1:0]      in_sel;
    logic            flush;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [3:0][7:0] out_data;
    logic            busy;

    int tests = 0;
    int fails = 0;

    logic [3:0] mv;
    logic [7:0] md [4];

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] rdy;
        logic       fl;
        logic       ir;
        logic [3:0] val;
        logic       dchk;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl [11];

    demux4_stream #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] rdy, input logic fl);
        rst_n = r; in_valid = v; in_sel = s; in_data = d; out_ready = rdy; flush = fl;
    endtask

    // Called at a negedge with inputs applied; returns at the following negedge.
    task automatic step(output logic ir);
        logic exp_ir;
        logic acc;
        #1;
        exp_ir = !flush && (!mv[in_sel] || out_ready[in_sel]);
        ir = in_ready;
        check("in_ready", ir, exp_ir);
        acc = in_valid && exp_ir;
        @(posedge clk);
        if (!rst_n) begin
            mv = 4'b0;
            for (int i = 0; i < 4; i++) md[i] = 8'h00;
        end else if (flush) begin
            mv = 4'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && in_sel == i) begin
                    mv[i] = 1'b1;
                    md[i] = in_data;
                end else if (out_ready[i]) begin
                    mv[i] = 1'b0;
                end
            end
        end
        #1;
        check("out_valid", out_valid, mv);
        check("busy", busy, |mv);
        for (int i = 0; i < 4; i++)
            if (mv[i]) check($sformatf("out_data[%0d]", i), out_data[i], md[i]);
        @(negedge clk);
    endtask

    initial begin
        logic ir;
        mv = 4'b0;
        for (int i = 0; i < 4; i++) md[i] = 8'h00;

        tbl[0]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h11};
        tbl[1]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, 1'b1, 4'b0011, 1'b1, 8'h22};
        tbl[2]  = '{1'b1, 2'd2, 8'h33, 4'b0000, 1'b0, 1'b1, 4'b0111, 1'b1, 8'h33};
        tbl[3]  = '{1'b1, 2'd3, 8'h44, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b1, 8'h44};
        tbl[4]  = '{1'b1, 2'd1, 8'h55, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1, 8'h22};
        tbl[5]  = '{1'b1, 2'd0, 8'h66, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1, 8'h11};
        tbl[6]  = '{1'b0, 2'd0, 8'h00, 4'b1000, 1'b0, 1'b0, 4'b0111, 1'b1, 8'h11};
        tbl[7]  = '{1'b1, 2'd0, 8'h77, 4'b0000, 1'b0, 1'b0, 4'b0111, 1'b1, 8'h11};
        tbl[8]  = '{1'b1, 2'd3, 8'h77, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b1, 8'h77};
        tbl[9]  = '{1'b1, 2'd1, 8'h99, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00};

        // reset held two cycles with a word offered
        drive(1'b0, 1'b1, 2'd2, 8'hAA, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 4'b0);
        check("rst out_data", out_data, 32'h0);
        check("rst busy", busy, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 8'hAA, 4'b0000, 1'b0);
        #1;
        check("post-rst in_ready", in_ready, 1'b1);

        // routing, head-of-line blocking, flush
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].rdy, tbl[k].fl);
            step(ir);
            check($sformatf("vec%0d in_ready", k), ir, tbl[k].ir);
            check($sformatf("vec%0d out_valid", k), out_valid, tbl[k].val);
            if (tbl[k].dchk)
                check($sformatf("vec%0d out_data", k), out_data[tbl[k].sel], tbl[k].dat);
        end

        // back-to-back streaming through channel 2
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b1, 2'd2, 8'(k), 4'b0100, 1'b0);
            step(ir);
            check("b2b in_ready", ir, 1'b1);
            check("b2b ch2 data", out_data[2], 32'(k));
            check("b2b ch2 valid", out_valid[2], 1'b1);
        end
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
        step(ir);

        // channel 1 stalled while others fill and drain
        drive(1'b1, 1'b1, 2'd1, 8'h5A, 4'b0000, 1'b0);
        step(ir);
        for (int k = 0; k < 10; k++) begin
            logic [1:0] s;
            s = (k % 3 == 0) ? 2'd0 : (k % 3 == 1) ? 2'd2 : 2'd3;
            drive(1'b1, 1'b1, s, 8'($urandom), {2'($urandom), 1'b0, 1'($urandom)}, 1'b0);
            step(ir);
            check("stall ch1 data", out_data[1], 8'h5A);
            check("stall ch1 valid", out_valid[1], 1'b1);
        end

        // mid-operation reset with slots 0 and 3 full and a drain offered
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
        step(ir);
        drive(1'b1, 1'b1, 2'd0, 8'hC0, 4'b0000, 1'b0);
        step(ir);
        drive(1'b1, 1'b1, 2'd3, 8'hC3, 4'b0000, 1'b0);
        step(ir);
        check("pre-rst valid", out_valid, 4'b1001);
        drive(1'b0, 1'b1, 2'd1, 8'hEE, 4'b0001, 1'b0);
        step(ir);
        check("midrst out_data", out_data, 32'h0);
        check("midrst out_valid", out_valid, 4'b0);

        // random traffic with occasional flush and reset
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 63) != 0), 1'($urandom), 2'($urandom), 8'($urandom),
                  4'($urandom), ($urandom_range(0, 15) == 0));
            step(ir);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
